// File: rtl/tdc_interval_meas_if.sv
// Result stream of the TDC interval measurement block: one interval per beat.
// A beat transfers on a rising clk edge where m_valid and m_ready are both high;
// m_valid never waits on m_ready, and m_data/m_ovf hold steady while m_valid & !m_ready.
interface tdc_interval_meas_if #(
    parameter int RES_W = 24
);
    logic             m_valid;
    logic             m_ready;
    logic             m_ovf;
    logic [RES_W-1:0] m_data;

    modport master (output m_valid, output m_data, output m_ovf, input m_ready);
    modport slave  (input m_valid, input m_data, input m_ovf, output m_ready);
endinterface

// File: rtl/tdc_interval_meas.sv
// TDC interval measurement: pairs start/stop hits, merges the free-running coarse
// count with the delayed fine codes and queues each interval in a small FWFT FIFO.
module tdc_interval_meas #(
    parameter int DEC_LAT      = 7,
    parameter int TAPS_PER_CLK = 40,
    parameter int COARSE_W     = 16,
    parameter int TIMEOUT      = 4095,
    parameter int RES_W        = 24,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                arm,
    input  logic                start_hit,
    input  logic                stop_hit,
    input  logic [5:0]          fine_start,
    input  logic [5:0]          fine_stop,
    tdc_interval_meas_if.master m,
    output logic                busy,
    output logic [7:0]          drop_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_ARMED, S_RUN, S_WAIT_FINE, S_CALC, S_PUSH
    } state_t;

    state_t              state;
    logic [COARSE_W-1:0] coarse, coarse_start, diff, elapsed;
    logic [DEC_LAT-1:0]  start_dly, stop_dly;
    logic [5:0]          fs_q, fp_q;
    logic                fs_got, fp_got, ovf;
    logic [RES_W-1:0]    result, calc;
    logic                start_tag, stop_tag;

    // Only hits that belong to the current measurement are tagged, so fine codes
    // of ignored hits travelling down the decoders are never captured.
    assign start_tag = (state == S_ARMED) && arm && start_hit;
    assign stop_tag  = (start_tag && stop_hit) || ((state == S_RUN) && stop_hit);
    assign elapsed   = coarse - coarse_start;
    assign busy      = (state != S_IDLE) && (state != S_ARMED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coarse    <= '0;
            start_dly <= '0;
            stop_dly  <= '0;
        end else begin
            coarse    <= coarse + 1'b1;
            start_dly <= {start_dly[DEC_LAT-2:0], start_tag};
            stop_dly  <= {stop_dly[DEC_LAT-2:0], stop_tag};
        end
    end

    always_comb begin
        calc = RES_W'(diff) * RES_W'(TAPS_PER_CLK) + RES_W'(fs_q) - RES_W'(fp_q);
        if ((diff == '0) && (fp_q > fs_q)) calc = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            coarse_start <= '0;
            diff         <= '0;
            fs_q         <= '0;
            fp_q         <= '0;
            fs_got       <= 1'b0;
            fp_got       <= 1'b0;
            ovf          <= 1'b0;
            result       <= '0;
        end else begin
            if (start_dly[DEC_LAT-1]) begin
                fs_q   <= fine_start;
                fs_got <= 1'b1;
            end
            if (stop_dly[DEC_LAT-1]) begin
                fp_q   <= fine_stop;
                fp_got <= 1'b1;
            end
            case (state)
                S_IDLE: if (arm) state <= S_ARMED;
                S_ARMED: begin
                    if (!arm) begin
                        state <= S_IDLE;
                    end else if (start_hit) begin
                        coarse_start <= coarse;
                        ovf          <= 1'b0;
                        fs_got       <= 1'b0;
                        fp_got       <= 1'b0;
                        if (stop_hit) begin
                            diff  <= '0;
                            state <= S_WAIT_FINE;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (stop_hit) begin
                        diff  <= elapsed;
                        state <= S_WAIT_FINE;
                    end else if (elapsed == COARSE_W'(TIMEOUT)) begin
                        diff  <= COARSE_W'(TIMEOUT);
                        ovf   <= 1'b1;
                        fp_q  <= '0;
                        state <= S_WAIT_FINE;
                    end
                end
                S_WAIT_FINE: if (fs_got && (fp_got || ovf)) state <= S_CALC;
                S_CALC: begin
                    result <= calc;
                    state  <= S_PUSH;
                end
                S_PUSH:  state <= arm ? S_ARMED : S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // FWFT FIFO; pointers carry an extra wrap bit to tell full from empty.
    logic [RES_W:0] mem [FIFO_DEPTH];
    logic [AW:0]    wr_ptr, rd_ptr;
    logic           empty, full, pop, push_req;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop      = !empty && m.m_ready;
    assign push_req = (state == S_PUSH);
    assign m.m_valid = !empty;
    assign {m.m_ovf, m.m_data} = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            drop_cnt <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push_req) begin
                if (!full || pop) begin
                    mem[wr_ptr[AW-1:0]] <= {ovf, result};
                    wr_ptr              <= wr_ptr + 1'b1;
                end else if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tdc_interval_meas.sv
// Bench for tdc_interval_meas: random and directed measurements driven through a
// decoder-latency model, results checked in order by a scoreboard monitor.
module tb_tdc_interval_meas;

    localparam int DEC_LAT  = 7;
    localparam int TAPS     = 40;
    localparam int COARSE_W = 16;
    localparam int TIMEOUT  = 4095;
    localparam int RES_W    = 24;
    localparam int DEPTH    = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       arm = 1'b0;
    logic       start_hit = 1'b0;
    logic       stop_hit = 1'b0;
    logic [5:0] fine_start = '0;
    logic [5:0] fine_stop = '0;
    logic       busy;
    logic [7:0] drop_cnt;

    tdc_interval_meas_if #(.RES_W(RES_W)) mif ();

    tdc_interval_meas #(
        .DEC_LAT(DEC_LAT), .TAPS_PER_CLK(TAPS), .COARSE_W(COARSE_W),
        .TIMEOUT(TIMEOUT), .RES_W(RES_W), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .start_hit(start_hit),
        .stop_hit(stop_hit), .fine_start(fine_start), .fine_stop(fine_stop),
        .m(mif), .busy(busy), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int             checks = 0;
    int             failures = 0;
    int             steps = 0;
    int             exp_drops = 0;
    bit             rnd_ready = 1'b0;
    bit             stalled = 1'b0;
    logic [RES_W:0] exp_q[$];
    logic [5:0]     fs_line[DEC_LAT+1];
    logic [5:0]     fp_line[DEC_LAT+1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic logic [5:0] rnd6();
        return 6'($urandom_range(0, 63));
    endfunction

    // Interval in taps straight from the measurement definition; gap < 0 means no stop.
    function automatic logic [RES_W:0] model(input int gap, input int fs, input int fp);
        int r;
        if (gap < 0) return {1'b1, RES_W'(TIMEOUT * TAPS + fs)};
        r = gap * TAPS + fs - fp;
        if (gap == 0 && fp > fs) r = 0;
        return {1'b0, RES_W'(r)};
    endfunction

    // One clock: hits for the coming edge, decoder outputs for hits DEC_LAT edges back.
    task automatic step(input logic s, input logic p, input logic [5:0] fs, input logic [5:0] fp);
        for (int i = DEC_LAT; i > 0; i--) begin
            fs_line[i] = fs_line[i-1];
            fp_line[i] = fp_line[i-1];
        end
        fs_line[0] = s ? fs : rnd6();
        fp_line[0] = p ? fp : rnd6();
        fine_start = fs_line[DEC_LAT];
        fine_stop  = fp_line[DEC_LAT];
        start_hit  = s;
        stop_hit   = p;
        if (rnd_ready) mif.m_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        steps++;
    endtask

    task automatic measure(input int gap, input int fs, input int fp, input bit chk_lat);
        logic [RES_W:0] e;
        int n;
        e = model(gap, fs, fp);
        if (stalled && exp_q.size() >= DEPTH) exp_drops++;
        else exp_q.push_back(e);
        if (gap == 0) begin
            step(1'b1, 1'b1, 6'(fs), 6'(fp));
        end else begin
            step(1'b1, 1'b0, 6'(fs), 6'd0);
            n = (gap < 0) ? TIMEOUT : gap - 1;
            for (int i = 0; i < n; i++) step($urandom_range(0, 7) == 0, 1'b0, rnd6(), rnd6());
            if (gap > 0) step(1'b0, 1'b1, 6'd0, 6'(fp));
        end
        // Hits right after the stop land while the block is finishing and must be ignored.
        for (int i = 1; i <= DEC_LAT + 5; i++) begin
            if (i <= 3) step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, rnd6(), rnd6());
            else step(1'b0, 1'b0, rnd6(), rnd6());
            if (chk_lat && i == DEC_LAT + 2) check("latency_early", 32'(mif.m_valid), 32'd0);
            if (chk_lat && i == DEC_LAT + 3) check("latency_on_time", 32'(mif.m_valid), 32'd1);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, rnd6(), rnd6());
    endtask

    // Scoreboard monitor: a beat seen just after the falling edge transfers on the next rising edge.
    initial begin
        logic [RES_W:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && mif.m_valid && mif.m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", {7'd0, mif.m_ovf, mif.m_data}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("result", {7'd0, mif.m_ovf, mif.m_data}, {7'd0, e});
                end
            end
        end
    end

    initial begin
        for (int i = 0; i <= DEC_LAT; i++) begin
            fs_line[i] = '0;
            fp_line[i] = '0;
        end
        mif.m_ready = 1'b1;
        arm = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_m_valid", 32'(mif.m_valid), 32'd0);
        check("reset_m_data", 32'(mif.m_data), 32'd0);
        check("reset_m_ovf", 32'(mif.m_ovf), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_drop_cnt", 32'(drop_cnt), 32'd0);
        rst_n = 1'b1;
        steps = 0;
        idle(2);

        measure(10, 20, 5, 1'b1);
        measure(0, 30, 12, 1'b0);
        measure(0, 5, 12, 1'b0);
        measure(-1, 9, 0, 1'b0);

        // Disarmed start and a lone stop while armed produce nothing.
        arm = 1'b0;
        idle(2);
        step(1'b1, 1'b0, rnd6(), rnd6());
        step(1'b0, 1'b1, rnd6(), rnd6());
        idle(DEC_LAT + 3);
        arm = 1'b1;
        idle(2);
        step(1'b0, 1'b1, rnd6(), rnd6());
        idle(DEC_LAT + 3);

        rnd_ready = 1'b1;
        for (int k = 0; k < 30; k++)
            measure(int'($urandom_range(0, 40)), int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), 1'b0);
        rnd_ready = 1'b0;
        mif.m_ready = 1'b1;
        idle(10);

        mif.m_ready = 1'b0;
        stalled = 1'b1;
        for (int k = 0; k < 5; k++)
            measure(int'($urandom_range(1, 30)), int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), 1'b0);
        check("drop_cnt", 32'(drop_cnt), 32'(exp_drops));
        stalled = 1'b0;
        mif.m_ready = 1'b1;
        idle(12);
        check("drain_valid_low", 32'(mif.m_valid), 32'd0);
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a run discards it.
        step(1'b1, 1'b0, 6'd11, 6'd0);
        idle(5);
        rst_n = 1'b0;
        #1;
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_valid", 32'(mif.m_valid), 32'd0);
        check("midreset_drop_cnt", 32'(drop_cnt), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        steps = 0;
        idle(2);
        measure(13, 40, 7, 1'b0);

        // Start sampled at coarse count 65530 so the stop falls after the wrap.
        while (steps < 65530) step(1'b0, 1'b0, rnd6(), rnd6());
        measure(20, 0, 0, 1'b0);

        idle(20);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
